eco32_core_wbu_rfw: RTL and testbench

Register-file write sequencer at the consumer end of the write-back request FIFO. Pops one entry at a time from the FIFO's strobe/ack output and converts it into register-file write cycles on a single write port, or into a scoreboard-release pulse. Each entry carries up to two halfword-enabled writes, A and B. A dual-write entry takes two cycles; every other entry takes one. It sits between the write-back FIFO and the 32-entry register file / scoreboard.

---
 rtl/eco32_core_wbu_rfw_if.sv | 26 ++
 rtl/eco32_core_wbu_rfw.sv | 139 +++++++++++++
 tb/tb_eco32_core_wbu_rfw.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/eco32_core_wbu_rfw_if.sv
// Write-back FIFO output port: one entry presented on strobe, popped by ack.
interface eco32_core_wbu_rfw_if;
    logic        i_stb;
    logic        i_clr;
    logic [4:0]  i_addr;
    logic [1:0]  i_a_ena;
    logic [31:0] i_a_data;
    logic        i_a_tag;
    logic [1:0]  i_b_ena;
    logic        i_b_mode;
    logic [31:0] i_b_data;
    logic        i_b_tag;
    logic        i_ack;

    modport master (
        output i_stb, i_clr, i_addr, i_a_ena, i_a_data, i_a_tag,
               i_b_ena, i_b_mode, i_b_data, i_b_tag,
        input  i_ack
    );

    modport slave (
        input  i_stb, i_clr, i_addr, i_a_ena, i_a_data, i_a_tag,
               i_b_ena, i_b_mode, i_b_data, i_b_tag,
        output i_ack
    );
endinterface

// File: rtl/eco32_core_wbu_rfw.sv
// Register-file write sequencer: turns write-back FIFO entries into RF writes or releases.
// Optional ECO32_WBU_RFW_MERGE_EN folds non-overlapping same-register DUAL entries into one write.
module eco32_core_wbu_rfw (
    input  logic                       clk,
    input  logic                       rst,
    eco32_core_wbu_rfw_if.slave        wb,
    output logic                       o_rf_we,
    output logic [4:0]                 o_rf_addr,
    output logic [1:0]                 o_rf_be,
    output logic [31:0]                o_rf_data,
    output logic                       o_rf_tag,
    output logic                       o_rel,
    output logic [4:0]                 o_rel_addr,
    output logic                       o_busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_B    = 1'b1
    } state_t;

    state_t      state_q;
    logic [4:0]  b_tgt_d, b_tgt_q;
    logic        a_on, b_on, merge_ok, single_op;

    logic        rf_we_q;
    logic [4:0]  rf_addr_q;
    logic [1:0]  rf_be_q;
    logic [31:0] rf_data_q;
    logic        rf_tag_q;
    logic        rel_q;
    logic [4:0]  rel_addr_q;

`ifdef ECO32_WBU_RFW_MERGE_EN
    logic [31:0] merge_data;
`endif

    always_comb begin
        a_on    = |wb.i_a_ena;
        b_on    = |wb.i_b_ena;
        b_tgt_d = wb.i_b_mode ? wb.i_addr : wb.i_addr + 5'd1;
`ifdef ECO32_WBU_RFW_MERGE_EN
        merge_ok = wb.i_b_mode && ((wb.i_a_ena & wb.i_b_ena) == 2'b00);
        merge_data[15:0]  = wb.i_b_ena[0] ? wb.i_b_data[15:0]  : wb.i_a_data[15:0];
        merge_data[31:16] = wb.i_b_ena[1] ? wb.i_b_data[31:16] : wb.i_a_data[31:16];
`else
        merge_ok = 1'b0;
`endif
        // NONE entries count as single-op: they are acked and dropped.
        single_op = wb.i_clr || !(a_on && b_on) || merge_ok;
        wb.i_ack  = ((state_q == S_IDLE) && wb.i_stb && single_op) || (state_q == S_B);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            b_tgt_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_be_q    <= '0;
            rf_data_q  <= '0;
            rf_tag_q   <= 1'b0;
            rel_q      <= 1'b0;
            rel_addr_q <= '0;
        end else begin
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_be_q    <= '0;
            rf_data_q  <= '0;
            rf_tag_q   <= 1'b0;
            rel_q      <= 1'b0;
            rel_addr_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (wb.i_stb) begin
                        if (wb.i_clr) begin
                            rel_q      <= 1'b1;
                            rel_addr_q <= wb.i_addr;
                        end else if (a_on && b_on) begin
                            rf_we_q   <= 1'b1;
                            rf_addr_q <= wb.i_addr;
`ifdef ECO32_WBU_RFW_MERGE_EN
                            if (merge_ok) begin
                                rf_be_q   <= wb.i_a_ena | wb.i_b_ena;
                                rf_data_q <= merge_data;
                                rf_tag_q  <= wb.i_b_tag;
                            end else begin
                                rf_be_q   <= wb.i_a_ena;
                                rf_data_q <= wb.i_a_data;
                                rf_tag_q  <= wb.i_a_tag;
                                b_tgt_q   <= b_tgt_d;
                                state_q   <= S_B;
                            end
`else
                            rf_be_q   <= wb.i_a_ena;
                            rf_data_q <= wb.i_a_data;
                            rf_tag_q  <= wb.i_a_tag;
                            b_tgt_q   <= b_tgt_d;
                            state_q   <= S_B;
`endif
                        end else if (a_on) begin
                            rf_we_q   <= 1'b1;
                            rf_addr_q <= wb.i_addr;
                            rf_be_q   <= wb.i_a_ena;
                            rf_data_q <= wb.i_a_data;
                            rf_tag_q  <= wb.i_a_tag;
                        end else if (b_on) begin
                            rf_we_q   <= 1'b1;
                            rf_addr_q <= b_tgt_d;
                            rf_be_q   <= wb.i_b_ena;
                            rf_data_q <= wb.i_b_data;
                            rf_tag_q  <= wb.i_b_tag;
                        end
                    end
                end
                S_B: begin
                    // Entry fields are held by the FIFO until this ack, so B data is read live.
                    rf_we_q   <= 1'b1;
                    rf_addr_q <= b_tgt_q;
                    rf_be_q   <= wb.i_b_ena;
                    rf_data_q <= wb.i_b_data;
                    rf_tag_q  <= wb.i_b_tag;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_rf_we    = rf_we_q;
    assign o_rf_addr  = rf_addr_q;
    assign o_rf_be    = rf_be_q;
    assign o_rf_data  = rf_data_q;
    assign o_rf_tag   = rf_tag_q;
    assign o_rel      = rel_q;
    assign o_rel_addr = rel_addr_q;
    assign o_busy     = (state_q == S_B);

endmodule

// File: tb/tb_eco32_core_wbu_rfw.sv
// Scoreboard bench for eco32_core_wbu_rfw: expected per-cycle outputs queued at drive time.
module tb_eco32_core_wbu_rfw;

    logic        clk = 1'b0;
    logic        rst;
    logic        o_rf_we;
    logic [4:0]  o_rf_addr;
    logic [1:0]  o_rf_be;
    logic [31:0] o_rf_data;
    logic        o_rf_tag;
    logic        o_rel;
    logic [4:0]  o_rel_addr;
    logic        o_busy;

    eco32_core_wbu_rfw_if wb_if ();

    eco32_core_wbu_rfw dut (
        .clk        (clk),
        .rst        (rst),
        .wb         (wb_if.slave),
        .o_rf_we    (o_rf_we),
        .o_rf_addr  (o_rf_addr),
        .o_rf_be    (o_rf_be),
        .o_rf_data  (o_rf_data),
        .o_rf_tag   (o_rf_tag),
        .o_rel      (o_rel),
        .o_rel_addr (o_rel_addr),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

`ifdef ECO32_WBU_RFW_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [1:0]  be;
        logic [31:0] data;
        logic        tag;
        logic        rel;
        logic [4:0]  raddr;
    } out_t;

    out_t sb[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic out_t wr(input logic [4:0] a, input logic [1:0] be,
                                input logic [31:0] d, input logic t);
        out_t r = '0;
        r.we = 1'b1; r.addr = a; r.be = be; r.data = d; r.tag = t;
        return r;
    endfunction

    function automatic out_t rl(input logic [4:0] a);
        out_t r = '0;
        r.rel = 1'b1; r.raddr = a;
        return r;
    endfunction

    task automatic chk_out(input out_t e);
        chk("rf_we",    32'(o_rf_we),    32'(e.we));
        chk("rf_addr",  32'(o_rf_addr),  32'(e.addr));
        chk("rf_be",    32'(o_rf_be),    32'(e.be));
        chk("rf_data",  o_rf_data,       e.data);
        chk("rf_tag",   32'(o_rf_tag),   32'(e.tag));
        chk("rel",      32'(o_rel),      32'(e.rel));
        chk("rel_addr", 32'(o_rel_addr), 32'(e.raddr));
    endtask

    // Inputs are already applied after a negedge; check ack/busy, queue next outputs, advance.
    task automatic tick(input logic exp_ack, input logic exp_busy, input out_t exp_next);
        out_t e;
        #1;
        chk("ack",  32'(wb_if.i_ack), 32'(exp_ack));
        chk("busy", 32'(o_busy),      32'(exp_busy));
        sb.push_back(exp_next);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk_out(e);
    endtask

    task automatic idle();
        wb_if.i_stb = 1'b0;
        tick(1'b0, 1'b0, '0);
    endtask

    task automatic run_entry(input logic clr, input logic [4:0] addr,
                             input logic [1:0] ae, input logic [31:0] ad, input logic at,
                             input logic [1:0] be, input logic bm,
                             input logic [31:0] bd, input logic bt);
        logic [4:0]  tgt;
        logic [31:0] md;
        wb_if.i_stb = 1'b1;  wb_if.i_clr = clr;     wb_if.i_addr = addr;
        wb_if.i_a_ena = ae;  wb_if.i_a_data = ad;   wb_if.i_a_tag = at;
        wb_if.i_b_ena = be;  wb_if.i_b_mode = bm;   wb_if.i_b_data = bd;
        wb_if.i_b_tag = bt;
        tgt = bm ? addr : 5'(addr + 5'd1);
        md  = {be[1] ? bd[31:16] : ad[31:16], be[0] ? bd[15:0] : ad[15:0]};
        if (clr)                                  tick(1'b1, 1'b0, rl(addr));
        else if (ae == 2'b00 && be == 2'b00)      tick(1'b1, 1'b0, '0);
        else if (be == 2'b00)                     tick(1'b1, 1'b0, wr(addr, ae, ad, at));
        else if (ae == 2'b00)                     tick(1'b1, 1'b0, wr(tgt, be, bd, bt));
        else if (MERGE && bm && (ae & be) == 2'b00)
                                                  tick(1'b1, 1'b0, wr(addr, ae | be, md, bt));
        else begin
            tick(1'b0, 1'b0, wr(addr, ae, ad, at));
            tick(1'b1, 1'b1, wr(tgt, be, bd, bt));
        end
    endtask

    initial begin
        rst = 1'b1;
        wb_if.i_stb = 1'b0;  wb_if.i_clr = 1'b0;   wb_if.i_addr = '0;
        wb_if.i_a_ena = '0;  wb_if.i_a_data = '0;  wb_if.i_a_tag = 1'b0;
        wb_if.i_b_ena = '0;  wb_if.i_b_mode = 1'b0; wb_if.i_b_data = '0;
        wb_if.i_b_tag = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ack", 32'(wb_if.i_ack), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk_out('0);
        rst = 1'b0;
        repeat (3) idle();

        // Back-to-back A-only then CLR
        run_entry(1'b0, 5'd3, 2'd3, 32'h1234_5678, 1'b1, 2'd0, 1'b0, 32'h0, 1'b0);
        run_entry(1'b1, 5'd7, 2'd3, 32'hDEAD_BEEF, 1'b0, 2'd3, 1'b0, 32'h0, 1'b0);
        idle();

        // DUAL with 31 -> 0 wrap
        run_entry(1'b0, 5'd31, 2'd1, 32'hCAFE_0001, 1'b0, 2'd2, 1'b0, 32'h0002_F00D, 1'b1);
        idle();

        // Same-halfword conflict, B lands last
        run_entry(1'b0, 5'd5, 2'd1, 32'h0000_AAAA, 1'b1, 2'd1, 1'b1, 32'h0000_BBBB, 1'b0);
        idle();

        // Merge candidate
        run_entry(1'b0, 5'd9, 2'd1, 32'h0000_1111, 1'b0, 2'd2, 1'b1, 32'h2222_0000, 1'b1);
        // NONE entry and B-only entry
        run_entry(1'b0, 5'd12, 2'd0, 32'h1, 1'b1, 2'd0, 1'b0, 32'h2, 1'b1);
        run_entry(1'b0, 5'd31, 2'd0, 32'h0, 1'b0, 2'd3, 1'b0, 32'h5555_6666, 1'b1);
        idle();

        // Reset asserted in the S_B cycle: B write abandoned
        wb_if.i_stb = 1'b1;  wb_if.i_clr = 1'b0;   wb_if.i_addr = 5'd20;
        wb_if.i_a_ena = 2'd3; wb_if.i_a_data = 32'h0A0A_0A0A; wb_if.i_a_tag = 1'b1;
        wb_if.i_b_ena = 2'd3; wb_if.i_b_mode = 1'b0; wb_if.i_b_data = 32'h0B0B_0B0B;
        wb_if.i_b_tag = 1'b0;
        tick(1'b0, 1'b0, wr(5'd20, 2'd3, 32'h0A0A_0A0A, 1'b1));
        rst = 1'b1;
        #1;
        chk("rstB_ack", 32'(wb_if.i_ack), 32'd0);
        chk("rstB_busy", 32'(o_busy), 32'd0);
        chk_out('0);
        @(posedge clk);
        @(negedge clk);
        chk("rstB_ack2", 32'(wb_if.i_ack), 32'd0);
        chk_out('0);
        wb_if.i_stb = 1'b0;
        rst = 1'b0;
        repeat (2) idle();

        // Random entries with occasional gaps
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            run_entry($urandom_range(0, 7) == 0, 5'($urandom), 2'($urandom), $urandom,
                      1'($urandom), 2'($urandom), 1'($urandom), $urandom, 1'($urandom));
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
